// File: rtl/demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_pkg : shared constants and helpers for demux_1to4_fifo        |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package demux_pkg;

  localparam int DEF_DATA_W = 2;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;

  // Occupancy needs one bit more than the pointer to represent "full".
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1to4_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_1to4_fifo_if : producer stream plus four consumer ports       |
// | Revision           : 1.0                                            |
// +--------------------------------------------------------------------+
interface demux_1to4_fifo_if #(
  parameter int DATA_W = demux_pkg::DEF_DATA_W,
  parameter int DEPTH  = 4
);
  import demux_pkg::*;

  localparam int CNT_W = count_w(DEPTH);

  logic [DATA_W-1:0] in;
  logic [1:0]        sel;
  logic              push;
  logic              in_ready;

  logic              pop_a, pop_b, pop_c, pop_d;
  logic [DATA_W-1:0] out_a, out_b, out_c, out_d;
  logic              valid_a, valid_b, valid_c, valid_d;
  logic              full_a, full_b, full_c, full_d;
  logic [CNT_W-1:0]  count_a, count_b, count_c, count_d;

  modport slave (
    input  in, sel, push, pop_a, pop_b, pop_c, pop_d,
    output in_ready,
    output out_a, out_b, out_c, out_d,
    output valid_a, valid_b, valid_c, valid_d,
    output full_a, full_b, full_c, full_d,
    output count_a, count_b, count_c, count_d
  );

  modport master (
    output in, sel, push, pop_a, pop_b, pop_c, pop_d,
    input  in_ready,
    input  out_a, out_b, out_c, out_d,
    input  valid_a, valid_b, valid_c, valid_d,
    input  full_a, full_b, full_c, full_d,
    input  count_a, count_b, count_c, count_d
  );

endinterface
`default_nettype wire

// File: rtl/demux_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_fifo : single-clock FIFO with occupancy count and flags       |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module demux_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       valid,
  output logic                       full,
  output logic [count_w(DEPTH)-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && valid;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign dout  = mem[rd_ptr];

  // Storage is deliberately left out of reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_1to4_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_1to4_fifo : routes a tagged word stream into four FIFOs       |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module demux_1to4_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  demux_1to4_fifo_if.slave   bus
);

  localparam int CNT_W = count_w(DEPTH);

  logic [3:0]        ch_push;
  logic [3:0]        ch_pop;
  logic [3:0]        ch_valid;
  logic [3:0]        ch_full;
  logic [DATA_W-1:0] ch_head  [4];
  logic [CNT_W-1:0]  ch_count [4];
  logic              in_ready;

  // Ready depends only on the selected channel's registered full flag.
  assign in_ready     = !ch_full[bus.sel];
  assign bus.in_ready = in_ready;
  assign ch_pop       = {bus.pop_d, bus.pop_c, bus.pop_b, bus.pop_a};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_ch
      assign ch_push[i] = bus.push && in_ready && (bus.sel == 2'(i));

      demux_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (ch_push[i]),
        .pop     (ch_pop[i]),
        .din     (bus.in),
        .dout    (ch_head[i]),
        .valid   (ch_valid[i]),
        .full    (ch_full[i]),
        .count   (ch_count[i])
      );
    end
  endgenerate

  assign bus.out_a   = ch_valid[CH_A] ? ch_head[CH_A] : '0;
  assign bus.out_b   = ch_valid[CH_B] ? ch_head[CH_B] : '0;
  assign bus.out_c   = ch_valid[CH_C] ? ch_head[CH_C] : '0;
  assign bus.out_d   = ch_valid[CH_D] ? ch_head[CH_D] : '0;

  assign bus.valid_a = ch_valid[CH_A];
  assign bus.valid_b = ch_valid[CH_B];
  assign bus.valid_c = ch_valid[CH_C];
  assign bus.valid_d = ch_valid[CH_D];

  assign bus.full_a  = ch_full[CH_A];
  assign bus.full_b  = ch_full[CH_B];
  assign bus.full_c  = ch_full[CH_C];
  assign bus.full_d  = ch_full[CH_D];

  assign bus.count_a = ch_count[CH_A];
  assign bus.count_b = ch_count[CH_B];
  assign bus.count_c = ch_count[CH_C];
  assign bus.count_d = ch_count[CH_D];

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_demux_1to4_fifo : queue-scoreboard bench for demux_1to4_fifo     |
// | Revision           : 1.0                                            |
// +--------------------------------------------------------------------+
module tb_demux_1to4_fifo;
  import demux_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = DEF_DATA_W;
  localparam int CNT_W  = count_w(DEPTH);

  logic clk     = 1'b0;
  logic reset_L = 1'b1;

  demux_1to4_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  demux_1to4_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] sb [4][$];

  function automatic logic [DATA_W-1:0] out_of(input int ch);
    case (ch)
      0:       return bus.out_a;
      1:       return bus.out_b;
      2:       return bus.out_c;
      default: return bus.out_d;
    endcase
  endfunction

  function automatic logic valid_of(input int ch);
    case (ch)
      0:       return bus.valid_a;
      1:       return bus.valid_b;
      2:       return bus.valid_c;
      default: return bus.valid_d;
    endcase
  endfunction

  function automatic logic full_of(input int ch);
    case (ch)
      0:       return bus.full_a;
      1:       return bus.full_b;
      2:       return bus.full_c;
      default: return bus.full_d;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] count_of(input int ch);
    case (ch)
      0:       return bus.count_a;
      1:       return bus.count_b;
      2:       return bus.count_c;
      default: return bus.count_d;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int ch);
    return CNT_W'(sb[ch].size());
  endfunction

  function automatic logic [DATA_W-1:0] exp_out(input int ch);
    if (sb[ch].size() != 0) return sb[ch][0];
    return '0;
  endfunction

  function automatic logic exp_ready(input int ch);
    return sb[ch].size() < DEPTH;
  endfunction

  task automatic drive(input logic [1:0] d, input logic [1:0] s, input logic p,
                       input logic [3:0] pops);
    bus.in   = d;
    bus.sel  = s;
    bus.push = p;
    {bus.pop_d, bus.pop_c, bus.pop_b, bus.pop_a} = pops;
  endtask

  // One rising edge; the scoreboard follows what the bench drove.
  task automatic tick();
    logic [3:0]        pops;
    logic              acc;
    int                s;
    logic [DATA_W-1:0] d;
    pops = {bus.pop_d, bus.pop_c, bus.pop_b, bus.pop_a};
    s    = int'(bus.sel);
    d    = bus.in;
    acc  = bus.push && exp_ready(s);
    @(posedge clk);
    for (int ch = 0; ch < 4; ch++) begin
      if (pops[ch] && sb[ch].size() != 0) void'(sb[ch].pop_front());
    end
    if (acc) sb[s].push_back(d);
    #1;
  endtask

  task automatic test_reset();
    drive(2'b00, 2'b00, 1'b0, 4'b0000);
    #1 reset_L = 1'b0;
    #1;
    for (int ch = 0; ch < 4; ch++) sb[ch].delete();
    for (int pass = 0; pass < 2; pass++) begin
      for (int ch = 0; ch < 4; ch++) begin
        vectors++;
        if (valid_of(ch) !== 1'b0 || count_of(ch) !== '0 || out_of(ch) !== '0) begin
          miscompares++;
          $display("FAIL reset_ch%0d: valid=%b count=%0d out=%b, want 0/0/00",
                   ch, valid_of(ch), count_of(ch), out_of(ch));
        end
      end
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      if (pass == 0) begin
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;
        repeat (3) tick();
      end
    end
  endtask

  task automatic test_routing();
    logic [1:0] w [4];
    w = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int ch = 0; ch < 4; ch++) begin
      drive(w[ch], ch[1:0], 1'b1, 4'b0000);
      tick();
      vectors++;
      if (count_of(ch) !== exp_cnt(ch) || valid_of(ch) !== 1'b1) begin
        miscompares++;
        $display("FAIL route_count_ch%0d: count=%0d valid=%b want %0d/1",
                 ch, count_of(ch), valid_of(ch), exp_cnt(ch));
      end
    end
    drive(2'b00, 2'b00, 1'b0, 4'b1111);
    #1;
    for (int ch = 0; ch < 4; ch++) begin
      vectors++;
      if (out_of(ch) !== exp_out(ch)) begin
        miscompares++;
        $display("FAIL route_out_ch%0d: got %b want %b", ch, out_of(ch), exp_out(ch));
      end
    end
    tick();
    drive(2'b00, 2'b00, 1'b0, 4'b0000);
    for (int ch = 0; ch < 4; ch++) begin
      vectors++;
      if (valid_of(ch) !== 1'b0 || out_of(ch) !== '0) begin
        miscompares++;
        $display("FAIL route_drain_ch%0d: valid=%b out=%b want 0/00",
                 ch, valid_of(ch), out_of(ch));
      end
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(2'(3 - k), 2'd2, 1'b1, 4'b0000);
      tick();
    end
    drive(2'b01, 2'd2, 1'b1, 4'b0000);
    #1;
    vectors++;
    if (full_of(2) !== !exp_ready(2) || bus.in_ready !== exp_ready(2)) begin
      miscompares++;
      $display("FAIL fill_full_c: full=%b in_ready=%b want %b/%b",
               full_of(2), bus.in_ready, !exp_ready(2), exp_ready(2));
    end
    tick();
    vectors++;
    if (count_of(2) !== exp_cnt(2) || out_of(2) !== exp_out(2)) begin
      miscompares++;
      $display("FAIL fill_overflow_c: count=%0d out=%b want %0d/%b",
               count_of(2), out_of(2), exp_cnt(2), exp_out(2));
    end
    drive(2'b10, 2'd0, 1'b1, 4'b0000);
    #1;
    vectors++;
    if (bus.in_ready !== exp_ready(0)) begin
      miscompares++;
      $display("FAIL fill_ready_a: got %b want %b", bus.in_ready, exp_ready(0));
    end
    tick();
    vectors++;
    if (count_of(0) !== exp_cnt(0) || out_of(0) !== exp_out(0)) begin
      miscompares++;
      $display("FAIL fill_accept_a: count=%0d out=%b want %0d/%b",
               count_of(0), out_of(0), exp_cnt(0), exp_out(0));
    end
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 2'd2, 1'b0, (k == 0) ? 4'b0101 : 4'b0100);
      #1;
      vectors++;
      if (out_of(2) !== exp_out(2) || valid_of(2) !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_order_c[%0d]: out=%b valid=%b want %b/1",
                 k, out_of(2), valid_of(2), exp_out(2));
      end
      tick();
    end
    vectors++;
    if (valid_of(2) !== 1'b0 || valid_of(0) !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_empty: valid_c=%b valid_a=%b want 0/0", valid_of(2), valid_of(0));
    end
  endtask

  task automatic test_full_pop();
    for (int k = 0; k < 4; k++) begin
      drive(2'(k), 2'd1, 1'b1, 4'b0000);
      tick();
    end
    drive(2'b11, 2'd1, 1'b1, 4'b0010);
    #1;
    vectors++;
    if (bus.in_ready !== exp_ready(1)) begin
      miscompares++;
      $display("FAIL fullpop_ready: got %b want %b", bus.in_ready, exp_ready(1));
    end
    tick();
    vectors++;
    if (count_of(1) !== exp_cnt(1) || count_of(1) !== CNT_W'(3)) begin
      miscompares++;
      $display("FAIL fullpop_refused: count_b=%0d want %0d", count_of(1), exp_cnt(1));
    end
    drive(2'b11, 2'd1, 1'b1, 4'b0000);
    tick();
    vectors++;
    if (count_of(1) !== exp_cnt(1) || full_of(1) !== 1'b1) begin
      miscompares++;
      $display("FAIL fullpop_accept: count_b=%0d full=%b want %0d/1",
               count_of(1), full_of(1), exp_cnt(1));
    end
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 2'd1, 1'b0, 4'b0010);
      #1;
      vectors++;
      if (out_of(1) !== exp_out(1)) begin
        miscompares++;
        $display("FAIL fullpop_order_b[%0d]: got %b want %b", k, out_of(1), exp_out(1));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [1:0] dv;
    for (int k = 0; k < 12; k++) begin
      dv = 2'(k) ^ 2'(k >> 2);
      drive(dv, 2'd3, 1'b1, (k > 0) ? 4'b1000 : 4'b0000);
      #1;
      if (k > 0) begin
        vectors++;
        if (out_of(3) !== exp_out(3)) begin
          miscompares++;
          $display("FAIL wrap_order_d[%0d]: got %b want %b", k, out_of(3), exp_out(3));
        end
      end
      tick();
      vectors++;
      if (count_of(3) !== exp_cnt(3)) begin
        miscompares++;
        $display("FAIL wrap_count_d[%0d]: got %0d want %0d", k, count_of(3), exp_cnt(3));
      end
    end
    drive(2'b00, 2'd3, 1'b0, 4'b1000);
    #1;
    vectors++;
    if (out_of(3) !== exp_out(3)) begin
      miscompares++;
      $display("FAIL wrap_last_d: got %b want %b", out_of(3), exp_out(3));
    end
    repeat (3) tick();
    vectors++;
    if (valid_of(3) !== 1'b0 || count_of(3) !== exp_cnt(3) || out_of(3) !== '0) begin
      miscompares++;
      $display("FAIL wrap_underflow_d: valid=%b count=%0d out=%b want 0/%0d/00",
               valid_of(3), count_of(3), out_of(3), exp_cnt(3));
    end
    drive(2'b00, 2'd0, 1'b0, 4'b0000);
  endtask

  task automatic test_reset_mid();
    int fill [4];
    fill = '{2, 4, 1, 3};
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < fill[ch]; k++) begin
        drive(2'(k + ch + 1), ch[1:0], 1'b1, 4'b0000);
        tick();
      end
    end
    drive(2'b00, 2'd1, 1'b0, 4'b0000);
    for (int ch = 0; ch < 4; ch++) begin
      vectors++;
      if (count_of(ch) !== exp_cnt(ch)) begin
        miscompares++;
        $display("FAIL midrst_pre_ch%0d: got %0d want %0d", ch, count_of(ch), exp_cnt(ch));
      end
    end
    #2 reset_L = 1'b0;
    #1;
    for (int ch = 0; ch < 4; ch++) sb[ch].delete();
    for (int ch = 0; ch < 4; ch++) begin
      vectors++;
      if (valid_of(ch) !== 1'b0 || count_of(ch) !== exp_cnt(ch) || out_of(ch) !== '0) begin
        miscompares++;
        $display("FAIL midrst_ch%0d: valid=%b count=%0d out=%b want 0/0/00",
                 ch, valid_of(ch), count_of(ch), out_of(ch));
      end
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1 reset_L = 1'b1;
    drive(2'b10, 2'd0, 1'b1, 4'b0000);
    tick();
    vectors++;
    if (count_of(0) !== exp_cnt(0) || out_of(0) !== exp_out(0)) begin
      miscompares++;
      $display("FAIL midrst_release: count_a=%0d out=%b want %0d/%b",
               count_of(0), out_of(0), exp_cnt(0), exp_out(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_routing();
    test_fill();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_1to4_fifo.md
# demux_1to4_fifo

Stream demultiplexer: one 2-bit input word stream, tagged with a 2-bit channel select, is routed into one of four per-channel FIFOs, each drained independently by its consumer. It is the distribution end of the 4-to-1 word selection path: a word that leaves a 4-to-1 selector on channel `sel` re-enters this block and comes out on the output with the same index. It buffers bursts so that one slow consumer stalls only traffic addressed to it.

## Interface
- `DATA_W`, 2, width of each data word.
- `DEPTH`, 4, entries per channel FIFO. Must be a power of two and at least 2.
- `clk`  input  1  single clock. All state updates on its rising edge.
- `reset_L`  input  1  asynchronous, active-low reset.
- `in`  input  DATA_W  input word.
- `sel`  input  2  destination channel: 0→a, 1→b, 2→c, 3→d.
- `push`  input  1  producer offers `in`/`sel` this cycle.
- `in_ready`  output  1  the FIFO selected by `sel` is not full.
- `pop_a`..`pop_d`  input  1 each  consumer removes the head word of its channel.
- `out_a`..`out_d`  output  DATA_W each  head word of the channel FIFO.
- `valid_a`..`valid_d`  output  1 each  the channel FIFO is non-empty.
- `full_a`..`full_d`  output  1 each  the channel FIFO holds `DEPTH` words.
- `count_a`..`count_d`  output  log2(DEPTH)+1 each  channel occupancy.

## Operation
- **Accept.** A word is accepted when `push && in_ready` at a rising edge of `clk`. It is written at the write pointer of FIFO[`sel`], and that pointer and count increment.
- **Push while not ready.** `push && !in_ready` is ignored. No state changes. The producer must hold `in`/`sel` until accepted.
- **Ready rule.** `in_ready` = !full[`sel`]. It is combinational from `sel` and the registered full flags. It does not depend on `push` or on any `pop_*`.
- **Pop.** `pop_x && valid_x` at a rising edge advances channel x's read pointer and decrements its count.
- **Pop while empty.** `pop_x` with `valid_x`=0 is ignored. Count stays at 0 and no underflow occurs.
- **Head word.** `out_x` is the word at the read pointer when `valid_x`=1. It is forced to 0 when the channel is empty, so stale memory is never exposed.
- **Simultaneous push and pop, same channel, not full.** Both take effect and the count is unchanged. The new word lands behind the existing ones.
- **Simultaneous push and pop, same channel, full.** The push is refused because `in_ready`=0. The pop completes. No pass-through.
- **Pointer wrap.** Pointers are log2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
- **Flags.** full = (count==DEPTH) and valid = (count!=0). Both are derived from the registered count.
- **Channel independence.** Channels are independent. Pushes to channel y proceed while channel x is full.
- **Ordering.** Ordering is FIFO within a channel. No ordering is guaranteed across channels.

## Timing
- **Reset values.** While `reset_L`=0, asynchronously:
  - all pointers and counts are 0;
  - `valid_*`=0, `full_*`=0, `count_*`=0, `out_*`=0;
  - `in_ready`=1.
- **Reset mid-operation.** Reset discards all buffered words immediately. Memory contents are not cleared, but they are unobservable because `out_*` is masked to 0 while empty.
- **Release from reset.** The first push can be accepted on the first rising edge after `reset_L` goes high.
- **Latency.** An accepted word is visible on `out_x` with `valid_x`=1 one cycle after the accepting edge, if the channel was empty.
- **Throughput.** One accepted word per cycle into the block. Each channel drains one word per cycle.
- **Flag timing.**
  - `full_x` and `in_ready` reflect a push on the edge after it.
  - A pop frees space on the following edge.
  - Worst-case full-to-accept turnaround is therefore 1 cycle.

## Structure
- **Shared package `demux_pkg`.** Holds:
  - `DATA_W` default;
  - channel-index localparams `CH_A`=0, `CH_B`=1, `CH_C`=2, `CH_D`=3;
  - a helper for the count width, log2(DEPTH)+1.
- **Sub-module `demux_fifo`.** One synchronous FIFO with push/pop, data in/out, valid, full and count. It is instantiated four times.
- **Top level.** Decodes `sel` into four one-hot push strobes gated by `push && in_ready`. It selects the full flag for `in_ready` and masks `out_*` to 0 when empty.

## Test plan
- **Reset check.** Apply reset, release, hold all inputs 0 for 3 cycles. Required: `in_ready`=1, all `valid_*`=0, all `count_*`=0, all `out_*`=0.
- **Basic routing.** Push (`in`,`sel`) = (2'b01,0), (2'b10,1), (2'b11,2), (2'b00,3) on consecutive cycles. Required:
  - each channel holds `count`=1 one cycle after its push;
  - `out_a`=01, `out_b`=10, `out_c`=11, `out_d`=00;
  - popping each channel returns `valid`=0.
- **Fill and back-pressure.** Push 3,2,1,0 to channel c, then a fifth push to c. Required:
  - `full_c`=1 and `in_ready`=0 while `sel`=2;
  - the fifth word is not stored;
  - with `sel`=0, `in_ready`=1 and channel a is still accepted;
  - popping c yields 3,2,1,0 in order.
- **Full with simultaneous pop.** With b full and `push`=1, `sel`=1, `pop_b`=1 in the same cycle. Required:
  - the push is refused and the pop is taken, so `count_b`=3;
  - the next cycle the push is accepted, so `count_b`=4.
- **Wrap and concurrent push/pop.** Stream 12 words to d while popping d every cycle from the second cycle on. Required: `count_d` stays 1, output order is intact across pointer wrap, and pops while empty at the end are ignored.
- **Reset mid-operation.** With channels holding 2,4,1,3 words, assert `reset_L`=0 between clock edges. Required: `valid_*`, `count_*`, `out_*` go to 0 immediately, before the next clock edge, and `in_ready`=1.
